// File: rtl/rampa_corriente_pkg.sv
// rampa_corriente_pkg: shared constants and FSM encoding for the current-ramp regulator
package rampa_corriente_pkg;
    localparam int DEF_STEP_PERIODS = 4;
    localparam int DEF_DUTY_W       = 5;
    localparam int CNT_W            = 4;
    typedef enum logic [1:0] {IDLE, WAIT, STEP, HOLD} estado_t;
endpackage

// File: rtl/rampa_corriente_contador.sv
// contador_periodos: counts PWM period ticks between duty steps
// Ports: clk, rst (sync, active-high), clr_i (clear, wins over tick),
//        tick_i (increment), tc_o (count sits one below N: the next tick completes the wait)
module contador_periodos
    import rampa_corriente_pkg::*;
#(
    parameter int N = DEF_STEP_PERIODS
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic tick_i,
    output logic tc_o
);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    always_comb cnt_d = clr_i ? '0 : tick_i ? cnt_q + 1'b1 : cnt_q;
    // Registered-only decode keeps the FSM free of a combinational loop through tick_i.
    assign tc_o = cnt_q == CNT_W'(N - 1);
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
endmodule

// File: rtl/rampa_corriente.sv
// rampa_corriente: ramps the PWM duty one LSB per STEP_PERIODS PWM periods toward Target
// Ports: CLK, Reset (sync, active-high), En (0 freezes everything), Target (requested duty),
//        Period_Tick (PWM counter wrap pulse), Duty (registered duty), Busy (ramp active),
//        Done (one-cycle pulse when Duty reaches Target)
module rampa_corriente
    import rampa_corriente_pkg::*;
#(
    parameter int STEP_PERIODS = DEF_STEP_PERIODS,
    parameter int DUTY_W       = DEF_DUTY_W
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              En,
    input  logic [DUTY_W-1:0] Target,
    input  logic              Period_Tick,
    output logic [DUTY_W-1:0] Duty,
    output logic              Busy,
    output logic              Done
);
    estado_t est_q, est_d;
    logic [DUTY_W-1:0] duty_q, duty_d, paso;
    logic clr, tick, tc, igual, sube, baja;
    contador_periodos #(.N(STEP_PERIODS)) u_cnt (
        .clk(CLK), .rst(Reset), .clr_i(clr), .tick_i(tick), .tc_o(tc)
    );
    assign igual = Target == duty_q;
    // Saturating: never step past either rail even if Target were out of reach.
    assign sube  = Target > duty_q && duty_q != '1;
    assign baja  = Target < duty_q && duty_q != '0;
    assign paso  = sube ? duty_q + 1'b1 : baja ? duty_q - 1'b1 : duty_q;
    always_comb begin
        est_d  = est_q;
        duty_d = duty_q;
        clr    = 1'b0;
        tick   = 1'b0;
        if (En) begin
            case (est_q)
                IDLE: if (!igual) begin
                    est_d = WAIT;
                    clr   = 1'b1;
                end
                WAIT: if (igual) est_d = HOLD;
                else if (Period_Tick) begin
                    tick  = 1'b1;
                    est_d = tc ? STEP : WAIT;
                end
                STEP: begin
                    duty_d = paso;
                    est_d  = paso == Target ? HOLD : WAIT;
                    clr    = 1'b1;
                end
                HOLD: est_d = IDLE;
                default: est_d = IDLE;
            endcase
        end
    end
    always_ff @(posedge CLK) begin
        if (Reset) begin
            est_q  <= IDLE;
            duty_q <= '0;
        end else begin
            est_q  <= est_d;
            duty_q <= duty_d;
        end
    end
    assign Duty = duty_q;
    assign Busy = est_q == WAIT || est_q == STEP;
    // Gated by En so a frozen HOLD cannot stretch the pulse.
    assign Done = En && est_q == HOLD;
endmodule

// File: tb/tb_rampa_corriente.sv
// tb_rampa_corriente: directed self-checking bench for rampa_corriente
module tb_rampa_corriente;
    logic       CLK = 1'b0;
    logic       Reset = 1'b1;
    logic       En = 1'b0;
    logic [4:0] Target = '0;
    logic       Period_Tick = 1'b0;
    logic [4:0] Duty;
    logic       Busy, Done;
    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    int dbase;

    rampa_corriente #(.STEP_PERIODS(4), .DUTY_W(5)) dut (
        .CLK(CLK), .Reset(Reset), .En(En), .Target(Target),
        .Period_Tick(Period_Tick), .Duty(Duty), .Busy(Busy), .Done(Done)
    );

    always #5 CLK = ~CLK;
    always @(negedge CLK) if (Done) done_cnt++;

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    // one PWM period of 32 cycles ending with the tick cycle
    task automatic tick1();
        repeat (31) cyc();
        Period_Tick = 1'b1;
        cyc();
        Period_Tick = 1'b0;
    endtask

    // four ticks, then the STEP cycle so Duty is updated on return
    task automatic step4();
        repeat (4) tick1();
        cyc();
    endtask

    task automatic rst_pulse();
        Reset = 1'b1;
        cyc();
        Reset = 1'b0;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        // reset state
        cyc();
        cyc();
        chk("rst_duty", Duty, 0);
        chk("rst_busy", Busy, 0);
        chk("rst_done", Done, 0);

        // ramp 0 -> 5
        Reset = 1'b0;
        En = 1'b1;
        Target = 5'd5;
        dbase = done_cnt;
        cyc();
        chk("t1_busy_wait", Busy, 1);
        chk("t1_duty0", Duty, 0);
        repeat (3) tick1();
        Period_Tick = 1'b1;
        cyc();
        Period_Tick = 1'b0;
        chk("t1_step_busy", Busy, 1);
        chk("t1_step_duty_old", Duty, 0);
        cyc();
        chk("t1_duty1", Duty, 1);
        step4();
        chk("t1_duty2", Duty, 2);
        step4();
        chk("t1_duty3", Duty, 3);
        step4();
        chk("t1_duty4", Duty, 4);
        step4();
        chk("t1_duty5", Duty, 5);
        chk("t1_done_hold", Done, 1);
        chk("t1_busy_hold", Busy, 0);
        cyc();
        chk("t1_done_idle", Done, 0);
        chk("t1_busy_idle", Busy, 0);
        chk("t1_done_count", done_cnt - dbase, 1);

        // ramp up to 20, then down to 17
        Target = 5'd20;
        cyc();
        repeat (15) step4();
        chk("t2_duty20", Duty, 20);
        cyc();
        dbase = done_cnt;
        Target = 5'd17;
        cyc();
        step4();
        chk("t2_duty19", Duty, 19);
        step4();
        chk("t2_duty18", Duty, 18);
        step4();
        chk("t2_duty17", Duty, 17);
        chk("t2_done", Done, 1);
        cyc();
        chk("t2_busy_after", Busy, 0);
        chk("t2_done_count", done_cnt - dbase, 1);

        // top rail: 30 -> 31 and no wrap
        Target = 5'd30;
        cyc();
        repeat (13) step4();
        chk("t3_duty30", Duty, 30);
        cyc();
        dbase = done_cnt;
        Target = 5'd31;
        cyc();
        step4();
        chk("t3_duty31", Duty, 31);
        cyc();
        repeat (10) step4();
        chk("t3_duty_sat", Duty, 31);
        chk("t3_busy", Busy, 0);
        chk("t3_done_count", done_cnt - dbase, 1);

        // target pulled back to current duty during WAIT
        rst_pulse();
        Target = 5'd10;
        cyc();
        repeat (3) step4();
        chk("t4_duty3", Duty, 3);
        repeat (2) tick1();
        dbase = done_cnt;
        Target = 5'd3;
        cyc();
        chk("t4_done", Done, 1);
        chk("t4_duty_hold", Duty, 3);
        chk("t4_busy_hold", Busy, 0);
        cyc();
        chk("t4_done_off", Done, 0);
        repeat (4) tick1();
        cyc();
        chk("t4_duty_still3", Duty, 3);
        chk("t4_done_count", done_cnt - dbase, 1);

        // En=0 freeze mid-WAIT with ticks present
        rst_pulse();
        dbase = done_cnt;
        Target = 5'd10;
        cyc();
        repeat (2) tick1();
        En = 1'b0;
        for (int i = 0; i < 200; i++) begin
            Period_Tick = (i % 32) == 0;
            cyc();
        end
        Period_Tick = 1'b0;
        chk("t5_duty_frozen", Duty, 0);
        chk("t5_busy_frozen", Busy, 1);
        chk("t5_no_done", done_cnt - dbase, 0);
        En = 1'b1;
        tick1();
        cyc();
        chk("t5_after_3rd", Duty, 0);
        tick1();
        cyc();
        chk("t5_after_4th", Duty, 1);

        // reset mid-ramp, reset beats simultaneous tick
        rst_pulse();
        Target = 5'd25;
        cyc();
        repeat (12) step4();
        chk("t6_duty12", Duty, 12);
        tick1();
        Reset = 1'b1;
        Period_Tick = 1'b1;
        cyc();
        chk("t6_rst_duty", Duty, 0);
        chk("t6_rst_busy", Busy, 0);
        chk("t6_rst_done", Done, 0);
        Reset = 1'b0;
        Period_Tick = 1'b0;
        cyc();
        chk("t6_restart_busy", Busy, 1);
        step4();
        chk("t6_restart_duty1", Duty, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/rampa_corriente.md
RAMPA_CORRIENTE -- requirements
Module: rampa_corriente

Interface
REQ-001 The block SHALL have parameter STEP_PERIODS, default 4: number of PWM periods between successive duty steps, legal range 1..15.
REQ-002 The block SHALL have parameter DUTY_W, default 5: width of the duty and target words.
REQ-003 The block SHALL have one clock and a synchronous active-high reset; no other clock or reset.
REQ-004 Port CLK, input, 1 bit: system clock; all state changes on its rising edge.
REQ-005 Port Reset, input, 1 bit: synchronous, active-high reset.
REQ-006 Port En, input, 1 bit: 1 = ramp runs; 0 = all state frozen.
REQ-007 Port Target, input, DUTY_W bits: requested current setting, sampled every cycle.
REQ-008 Port Period_Tick, input, 1 bit: one-cycle pulse when the PWM counter wraps to 0.
REQ-009 Port Duty, output, DUTY_W bits: registered duty value driven to the PWM comparator.
REQ-010 Port Busy, output, 1 bit: 1 while Duty != Target or a step is pending.
REQ-011 Port Done, output, 1 bit: one-cycle pulse when Duty reaches Target.

Function
REQ-012 The block SHALL implement the FSM states IDLE, WAIT, STEP, HOLD.
REQ-013 IDLE: Duty equals Target; Busy=0. When Target != Duty and En=1, the FSM SHALL move to WAIT on the next edge and clear the period counter.
REQ-014 WAIT: the period counter SHALL increment on each Period_Tick; on the tick that makes the count equal STEP_PERIODS, the FSM SHALL move to STEP.
REQ-015 STEP: Duty SHALL change by exactly 1 LSB toward the Target value sampled in that cycle, then:
- go to HOLD if the new Duty equals Target;
- otherwise go to WAIT with the counter cleared.
REQ-016 HOLD: Done SHALL be 1 for that single cycle; the FSM SHALL return to IDLE on the next cycle.
REQ-017 Duty SHALL change only in the STEP state, which is entered only on a Period_Tick cycle, so Duty never changes mid-PWM-period.
REQ-018 Step arithmetic SHALL be unsigned and saturating: no step below 0 or above 2^DUTY_W-1. Wrap-around is forbidden.
REQ-019 If Target changes during WAIT, the ramp SHALL continue toward the new Target without resetting the counter.
REQ-020 If the new Target equals the current Duty during WAIT, the FSM SHALL go to HOLD on the next edge (Done pulse) and Duty SHALL be unchanged.
REQ-021 If Target crosses Duty in the same cycle as STEP, the step direction SHALL follow the Target sampled in the STEP cycle.
REQ-022 With En=0, the state, counter and Duty SHALL hold, Period_Tick SHALL be ignored, and Done SHALL NOT pulse; resuming SHALL continue from the held state.
REQ-023 Simultaneous Reset and any other input: Reset SHALL win.
REQ-024 Busy SHALL be 1 in WAIT and STEP, and 0 in IDLE and HOLD.
REQ-025 Latency from Target change to first Duty step SHALL be STEP_PERIODS Period_Ticks plus 1 cycle.

Reset
REQ-026 On Reset=1 at a clock edge, the block SHALL set state=IDLE, Duty=0, period counter=0, Busy=0, Done=0.
REQ-027 A reset asserted mid-ramp SHALL abort the ramp immediately; after release, the ramp SHALL restart from Duty=0 toward the current Target.

Structure
REQ-028 State encodings, the default STEP_PERIODS and DUTY_W SHALL live in a shared constants include/package used by the regulator blocks.
REQ-029 The period counter SHALL be a separate sub-module, contador_periodos (clear, tick-enable, terminal-count output); the FSM and duty register stay in rampa_corriente.
REQ-030 The block SHALL sit between Contador_Corriente's output and the comparator's A input; Period_Tick SHALL come from the 5-bit PWM counter wrap.

Verification
REQ-031 Reset, then Target=5, STEP_PERIODS=4, tick every 32 cycles -> Duty steps 0→1→…→5, one step per 4 ticks; one Done pulse; Busy low after.
REQ-032 Duty=20 at rest, Target set to 17 -> Duty 19, 18, 17 on successive 4th ticks; no underflow; Done once.
REQ-033 Target=31 from Duty=30, then hold Target=31 for 10 more steps -> Duty stops at 31, never wraps to 0.
REQ-034 Mid-ramp (Duty=3, heading to 10), Target changed to 3 during WAIT -> HOLD next edge, Done pulse, Duty stays 3.
REQ-035 En=0 for 200 cycles mid-WAIT with ticks present -> Duty and counter frozen; on En=1 the step occurs after the remaining ticks only.
REQ-036 Reset asserted at Duty=12 heading to 25 -> next edge Duty=0, Busy=0; after release the ramp restarts toward 25.
